// File: rtl/arb_merge3_sync_ctrl_pkg.sv
// Shared types and helpers for the arbitrated-merge synchronous front-end.
package arb_merge3_sync_ctrl_pkg;

    localparam int unsigned NUM_SRC = 3;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned PH_W    = 2;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DRIVE     = 3'd1,
        S_WAIT_F0   = 3'd2,
        S_WAIT_F1   = 3'd3,
        S_WAIT_FREE = 3'd4,
        S_ACK       = 3'd5
    } state_t;

    localparam logic [PH_W-1:0] PH_IDLE = 2'd0;
    localparam logic [PH_W-1:0] PH_F0   = 2'd1;
    localparam logic [PH_W-1:0] PH_F1   = 2'd2;
    localparam logic [PH_W-1:0] PH_FREE = 2'd3;

    // Next source index after idx, wrapping modulo NUM_SRC.
    function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] idx);
        return (idx >= SEL_W'(NUM_SRC - 1)) ? '0 : idx + SEL_W'(1);
    endfunction

    // First requester at or after ptr in round-robin order.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                                 input logic [SEL_W-1:0]   ptr);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] pick;
        logic             found;
        idx   = ptr;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = rr_next(idx);
        end
        return pick;
    endfunction

endpackage

// File: rtl/arb_merge3_sync_ctrl_toggle_sync_edge.sv
// Multi-flop synchronizer for a 2-phase toggle input, with XOR edge detect
// producing a one-cycle pulse per toggle.
module arb_merge3_sync_ctrl_toggle_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_evt_c
);

    logic [SYNC_STAGES-1:0] sync_d, sync_q;
    logic                   ref_d, ref_q;

    // Shift the async level in; keep a copy of the synced level for edge detect.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
        ref_d  = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and reference flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            ref_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            ref_q  <= ref_d;
        end
    end

    assign o_evt_c = sync_q[SYNC_STAGES-1] ^ ref_q;

endmodule

// File: rtl/arb_merge3_sync_ctrl.sv
// Round-robin request/ack front-end for the 3-stage arbitrated-merge pipeline.
// Optional abort-on-stall: define ARB_MERGE3_TIMEOUT_EN.
module arb_merge3_sync_ctrl
    import arb_merge3_sync_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
`ifdef ARB_MERGE3_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] i_req,
    output logic [NUM_SRC-1:0] o_ack,
    output logic [SEL_W-1:0]   o_sel,
    output logic               o_busy,
    output logic               o_drive,
    input  logic [1:0]         i_fire_2,
    input  logic               i_free,
    output logic [PH_W-1:0]    o_phase,
    output logic               o_err
);

    state_t             state_d, state_q;
    logic [NUM_SRC-1:0] ack_d, ack_q;
    logic [SEL_W-1:0]   sel_d, sel_q;
    logic [SEL_W-1:0]   rr_d, rr_q;
    logic               busy_d, busy_q;
    logic               drive_d, drive_q;
    logic [PH_W-1:0]    phase_d, phase_q;
    logic               err_d, err_q;
    logic               pend_f0_d, pend_f0_q;
    logic               pend_f1_d, pend_f1_q;
    logic               pend_free_d, pend_free_q;
`ifdef ARB_MERGE3_TIMEOUT_EN
    logic [TO_W-1:0]    to_cnt_d, to_cnt_q;
`endif

    logic evt_f0_c, evt_f1_c, evt_free_c, any_evt_c;

    arb_merge3_sync_ctrl_toggle_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_f0 (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_fire_2[0]),
        .o_evt_c (evt_f0_c)
    );

    arb_merge3_sync_ctrl_toggle_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_f1 (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_fire_2[1]),
        .o_evt_c (evt_f1_c)
    );

    arb_merge3_sync_ctrl_toggle_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_free (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_free),
        .o_evt_c (evt_free_c)
    );

    assign any_evt_c = evt_f0_c | evt_f1_c | evt_free_c;

    // Next-state, event bookkeeping and registered-output logic.
    always_comb begin
        state_d     = state_q;
        ack_d       = '0;
        sel_d       = sel_q;
        rr_d        = rr_q;
        busy_d      = busy_q;
        drive_d     = drive_q;
        phase_d     = phase_q;
        err_d       = err_q;
        pend_f0_d   = pend_f0_q;
        pend_f1_d   = pend_f1_q;
        pend_free_d = pend_free_q;

        unique case (state_q)
            S_IDLE: begin
                if (any_evt_c) err_d = 1'b1;
                pend_f0_d   = 1'b0;
                pend_f1_d   = 1'b0;
                pend_free_d = 1'b0;
                if (|i_req) begin
                    sel_d   = rr_pick(i_req, rr_q);
                    busy_d  = 1'b1;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE, S_WAIT_F0: begin
                // Later events are only legal once every earlier one is held.
                pend_f0_d = pend_f0_q | evt_f0_c;
                if (evt_f1_c) begin
                    if (pend_f0_d) pend_f1_d = 1'b1;
                    else           err_d     = 1'b1;
                end
                if (evt_free_c) begin
                    if (pend_f1_d) pend_free_d = 1'b1;
                    else           err_d       = 1'b1;
                end
                if (state_q == S_DRIVE) begin
                    drive_d = ~drive_q;
                    phase_d = PH_IDLE;
                    state_d = S_WAIT_F0;
                end else if (pend_f0_d) begin
                    pend_f0_d = 1'b0;
                    phase_d   = PH_F0;
                    state_d   = S_WAIT_F1;
                end
            end
            S_WAIT_F1: begin
                pend_f1_d = pend_f1_q | evt_f1_c;
                if (evt_free_c) begin
                    if (pend_f1_d) pend_free_d = 1'b1;
                    else           err_d       = 1'b1;
                end
                if (pend_f1_d) begin
                    pend_f1_d = 1'b0;
                    phase_d   = PH_F1;
                    state_d   = S_WAIT_FREE;
                end
            end
            S_WAIT_FREE: begin
                pend_free_d = pend_free_q | evt_free_c;
                if (pend_free_d) begin
                    pend_free_d  = 1'b0;
                    phase_d      = PH_FREE;
                    ack_d[sel_q] = 1'b1;
                    state_d      = S_ACK;
                end
            end
            S_ACK: begin
                if (any_evt_c) err_d = 1'b1;
                pend_f0_d   = 1'b0;
                pend_f1_d   = 1'b0;
                pend_free_d = 1'b0;
                busy_d      = 1'b0;
                rr_d        = rr_next(sel_q);
                phase_d     = PH_IDLE;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef ARB_MERGE3_TIMEOUT_EN
        // Stall watchdog: abort through ACK so the requester is still released.
        to_cnt_d = (state_d != state_q) ? '0 : to_cnt_q + TO_W'(1);
        if ((state_q == S_WAIT_F0 || state_q == S_WAIT_F1 || state_q == S_WAIT_FREE) &&
            (state_d == state_q) && (to_cnt_q == TO_W'(TIMEOUT - 1))) begin
            err_d        = 1'b1;
            ack_d        = '0;
            ack_d[sel_q] = 1'b1;
            phase_d      = PH_IDLE;
            pend_f0_d    = 1'b0;
            pend_f1_d    = 1'b0;
            pend_free_d  = 1'b0;
            to_cnt_d     = '0;
            state_d      = S_ACK;
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ack_q       <= '0;
            sel_q       <= '0;
            rr_q        <= '0;
            busy_q      <= 1'b0;
            drive_q     <= 1'b0;
            phase_q     <= PH_IDLE;
            err_q       <= 1'b0;
            pend_f0_q   <= 1'b0;
            pend_f1_q   <= 1'b0;
            pend_free_q <= 1'b0;
`ifdef ARB_MERGE3_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            sel_q       <= sel_d;
            rr_q        <= rr_d;
            busy_q      <= busy_d;
            drive_q     <= drive_d;
            phase_q     <= phase_d;
            err_q       <= err_d;
            pend_f0_q   <= pend_f0_d;
            pend_f1_q   <= pend_f1_d;
            pend_free_q <= pend_free_d;
`ifdef ARB_MERGE3_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign o_ack   = ack_q;
    assign o_sel   = sel_q;
    assign o_busy  = busy_q;
    assign o_drive = drive_q;
    assign o_phase = phase_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_arb_merge3_sync_ctrl.sv
// Scoreboard bench for arb_merge3_sync_ctrl: directed transactions push the
// expected acknowledge; a monitor checks every o_ack the DUT presents.
module tb_arb_merge3_sync_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] i_req;
    logic [2:0] o_ack;
    logic [1:0] o_sel;
    logic       o_busy;
    logic       o_drive;
    logic [1:0] i_fire_2;
    logic       i_free;
    logic [1:0] o_phase;
    logic       o_err;

    arb_merge3_sync_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .o_ack    (o_ack),
        .o_sel    (o_sel),
        .o_busy   (o_busy),
        .o_drive  (o_drive),
        .i_fire_2 (i_fire_2),
        .i_free   (i_free),
        .o_phase  (o_phase),
        .o_err    (o_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ack;
        logic [1:0] sel;
        logic       drive;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_drive = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every acknowledge the DUT shows must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && o_ack !== 3'b000) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ack: got %b expected none", o_ack);
            end else begin
                e = exp_q.pop_front();
                check("ack_vec",   32'(o_ack),   32'(e.ack));
                check("ack_sel",   32'(o_sel),   32'(e.sel));
                check("ack_busy",  32'(o_busy),  32'd1);
                check("ack_drive", 32'(o_drive), 32'(e.drive));
                check("ack_err",   32'(o_err),   32'(e.err));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input logic [1:0] ph, input string name);
        @(negedge clk);
        for (int k = 0; k < 40 && o_phase !== ph; k++) @(negedge clk);
        check(name, 32'(o_phase), 32'(ph));
    endtask

    task automatic wait_drive(input logic lvl, input string name);
        @(negedge clk);
        for (int k = 0; k < 40 && o_drive !== lvl; k++) @(negedge clk);
        check(name, 32'(o_drive), 32'(lvl));
    endtask

    task automatic wait_err(input string name);
        @(negedge clk);
        for (int k = 0; k < 40 && o_err !== 1'b1; k++) @(negedge clk);
        check(name, 32'(o_err), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},   32'(o_ack),   32'd0);
        check({tag, "_sel"},   32'(o_sel),   32'd0);
        check({tag, "_busy"},  32'(o_busy),  32'd0);
        check({tag, "_drive"}, 32'(o_drive), 32'd0);
        check({tag, "_phase"}, 32'(o_phase), 32'd0);
        check({tag, "_err"},   32'(o_err),   32'd0);
    endtask

    // One transaction for the source expected to win; optional burst of
    // simultaneous events, optional early free to provoke a protocol error.
    task automatic run_txn(input logic [1:0] src, input logic exp_err,
                           input bit burst, input bit inject, input bit drop);
        logic [2:0] oh;
        oh = 3'b001 << src;
        exp_drive = ~exp_drive;
        exp_q.push_back({oh, src, exp_drive, exp_err});
        wait_drive(exp_drive, "drive_toggle");
        check("grant_sel", 32'(o_sel), 32'(src));
        if (inject) begin
            step();
            i_free = ~i_free;
            wait_err("err_set");
            check("err_hold_phase", 32'(o_phase), 32'd0);
        end
        step();
        if (burst) begin
            i_fire_2 = ~i_fire_2;
            i_free   = ~i_free;
            wait_phase(2'd1, "burst_ph1");
            @(negedge clk);
            check("burst_ph2", 32'(o_phase), 32'd2);
            @(negedge clk);
            check("burst_ph3", 32'(o_phase), 32'd3);
            check("burst_err", 32'(o_err), 32'd0);
        end else begin
            i_fire_2[0] = ~i_fire_2[0];
            wait_phase(2'd1, "phase_f0");
            step();
            i_fire_2[1] = ~i_fire_2[1];
            wait_phase(2'd2, "phase_f1");
            step();
            i_free = ~i_free;
            wait_phase(2'd3, "phase_free");
        end
        step();
        if (drop) i_req = 3'b000;
    endtask

    initial begin
        rst      = 1'b1;
        i_req    = 3'b000;
        i_fire_2 = 2'b00;
        i_free   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        step();
        rst = 1'b0;
        step();

        // Single request from source 1 with grant/drive latency checks.
        i_req = 3'b010;
        @(negedge clk);
        check("pre_grant_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        check("grant_busy", 32'(o_busy), 32'd1);
        check("grant_sel1", 32'(o_sel), 32'd1);
        check("drive_not_yet", 32'(o_drive), 32'd0);
        @(negedge clk);
        check("drive_2cyc", 32'(o_drive), 32'd1);
        exp_drive = 1'b0;
        run_txn(2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("post_ack_busy", 32'(o_busy), 32'd0);
        check("post_ack_ack", 32'(o_ack), 32'd0);

        // Contention: all three held; round-robin from pointer 2.
        step();
        i_req = 3'b111;
        run_txn(2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        run_txn(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_txn(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_txn(2'd2, 1'b0, 1'b0, 1'b0, 1'b1);

        // Simultaneous fire0/fire1/free; pointer is now 0, only source 2 asks.
        step();
        i_req = 3'b100;
        run_txn(2'd2, 1'b0, 1'b1, 1'b0, 1'b1);

        // Early free while waiting for fire0 sets the sticky error.
        step();
        i_req = 3'b001;
        run_txn(2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(o_err), 32'd1);

        // Reset in WAIT_F1 aborts with no acknowledge.
        step();
        i_req = 3'b010;
        exp_drive = ~exp_drive;
        wait_drive(exp_drive, "rst_txn_drive");
        step();
        i_fire_2[0] = ~i_fire_2[0];
        wait_phase(2'd1, "rst_txn_f0");
        step();
        rst      = 1'b1;
        i_req    = 3'b000;
        i_fire_2 = 2'b00;
        i_free   = 1'b0;
        exp_drive = 1'b0;
        #1;
        check_all_zero("async_rst");
        step();
        step();
        rst = 1'b0;
        step();
        i_req = 3'b001;
        run_txn(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
